// File: rtl/sample_delay_line.sv
// -----------------------------------------------------------------------------
// sample_delay_line
// Single-clock circular-buffer delay line for the audio effects path. Each
// accepted sample strobe produces the dry sample and a tap delayed by a
// runtime-selectable number of samples. One sample per two cycles at most.
//
// Optional build macro:
//   DELAY_FEEDBACK_EN - recirculating echo: the stored value becomes
//                       saturate(sample + (tap >>> FB_SHIFT)).
//
// Parameters:
//   DATA_W   - signed sample width
//   ADDR_W   - buffer address width (DEPTH = 2**ADDR_W, max delay DEPTH-1)
//   FB_SHIFT - feedback attenuation shift (feedback build only)
//
// Ports:
//   clkMain    in   system clock, rising edge
//   resetN     in   synchronous active-low reset
//   sampleStb  in   one-cycle strobe, new sample on inData
//   inData     in   signed input sample
//   delay      in   tap delay in samples, sampled on accepted strobes
//   outDry     out  registered accepted sample
//   outDelayed out  registered delayed tap
//   outValid   out  one-cycle pulse when outDry/outDelayed update
// -----------------------------------------------------------------------------
module sample_delay_line #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned FB_SHIFT = 1
) (
    input  logic                     clkMain,
    input  logic                     resetN,
    input  logic                     sampleStb,
    input  logic signed [DATA_W-1:0] inData,
    input  logic        [ADDR_W-1:0] delay,
    output logic signed [DATA_W-1:0] outDry,
    output logic signed [DATA_W-1:0] outDelayed,
    output logic                     outValid
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(DEPTH - 1);

    // Elaboration-time parameter sanity checks
    if (ADDR_W < 1) begin : g_bad_addr_w
        $error("sample_delay_line: ADDR_W must be at least 1");
    end
    if (DATA_W < 2) begin : g_bad_data_w
        $error("sample_delay_line: DATA_W must be at least 2");
    end
    if (FB_SHIFT >= DATA_W) begin : g_bad_fb_shift
        $error("sample_delay_line: FB_SHIFT must be below DATA_W");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept_c;
    logic commit_c;

    logic        [ADDR_W-1:0] wr_ptr;
    logic        [ADDR_W-1:0] fill_count;
    logic        [ADDR_W-1:0] delay_reg;
    logic signed [DATA_W-1:0] in_reg;
    logic signed [DATA_W-1:0] rd_data;

    logic        [ADDR_W-1:0] rd_addr_c;
    logic signed [DATA_W-1:0] tap_c;
    logic signed [DATA_W-1:0] wr_val_c;

    logic signed [DATA_W-1:0] mem [DEPTH];

    // State register
    always_ff @(posedge clkMain) begin
        if (!resetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a strobe seen while writing is dropped, not queued
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sampleStb) state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequencer controls
    always_comb begin
        accept_c = 1'b0;
        commit_c = 1'b0;
        case (state)
            S_IDLE:  accept_c = sampleStb;
            S_WRITE: commit_c = 1'b1;
            default: ;
        endcase
    end

    // Read address wraps naturally in ADDR_W bits
    assign rd_addr_c = wr_ptr - delay;

    // Tap select: bypass, never-written slot, or buffered sample
    always_comb begin
        tap_c = rd_data;
        if (delay_reg == '0) begin
            tap_c = in_reg;
        end else if (delay_reg > fill_count) begin
            tap_c = '0;
        end
    end

`ifdef DELAY_FEEDBACK_EN
    logic signed [DATA_W-1:0] fb_c;
    logic signed [DATA_W:0]   sum_c;

    // Feedback adder with saturation to the signed sample range
    always_comb begin
        fb_c     = '0;
        sum_c    = '0;
        wr_val_c = in_reg;
        if (delay_reg != '0) begin
            fb_c = tap_c >>> FB_SHIFT;
        end
        sum_c = {in_reg[DATA_W-1], in_reg} + {fb_c[DATA_W-1], fb_c};
        if (sum_c[DATA_W] != sum_c[DATA_W-1]) begin
            wr_val_c = sum_c[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            wr_val_c = sum_c[DATA_W-1:0];
        end
    end
`else
    assign wr_val_c = in_reg;
`endif

    // Sample buffer: synchronous read on accept, write one cycle later.
    // Contents survive reset; fill_count masks stale entries.
    always_ff @(posedge clkMain) begin
        if (accept_c) begin
            rd_data <= mem[rd_addr_c];
        end
        if (resetN && commit_c) begin
            mem[wr_ptr] <= wr_val_c;
        end
    end

    // Datapath registers and outputs
    always_ff @(posedge clkMain) begin
        if (!resetN) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            delay_reg  <= '0;
            in_reg     <= '0;
            outDry     <= '0;
            outDelayed <= '0;
            outValid   <= 1'b0;
        end else begin
            outValid <= commit_c;
            if (accept_c) begin
                in_reg    <= inData;
                delay_reg <= delay;
            end
            if (commit_c) begin
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                outDry     <= in_reg;
                outDelayed <= tap_c;
                if (fill_count != FILL_MAX) begin
                    fill_count <= fill_count + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_delay_line.sv
// -----------------------------------------------------------------------------
// tb_sample_delay_line
// Randomised and directed stimulus for sample_delay_line (ADDR_W=4) checked
// each cycle against a sample-history reference model.
// -----------------------------------------------------------------------------
module tb_sample_delay_line;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int DEPTH = 16;
    localparam int FB_SH = 1;

    logic                     clkMain = 1'b0;
    logic                     resetN;
    logic                     sampleStb;
    logic signed [DATA_W-1:0] inData;
    logic        [ADDR_W-1:0] delay;
    logic signed [DATA_W-1:0] outDry;
    logic signed [DATA_W-1:0] outDelayed;
    logic                     outValid;

    always #5 clkMain = ~clkMain;

    sample_delay_line #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .FB_SHIFT(FB_SH)
    ) dut (
        .clkMain   (clkMain),
        .resetN    (resetN),
        .sampleStb (sampleStb),
        .inData    (inData),
        .delay     (delay),
        .outDry    (outDry),
        .outDelayed(outDelayed),
        .outValid  (outValid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: history of stored values since reset
    int hist[$];
    bit busy;
    int pend_data;
    int pend_dly;
    int e_valid;
    int e_dry;
    int e_del;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_edge(input bit stb, input int d, input int dl, input bit rst);
        if (!rst) begin
            e_valid = 0;
            e_dry   = 0;
            e_del   = 0;
            busy    = 0;
            hist.delete();
        end else if (busy) begin
            int n;
            int fill;
            int tap;
            int wv;
            n    = hist.size();
            fill = (n > DEPTH - 1) ? DEPTH - 1 : n;
            if (pend_dly == 0)       tap = pend_data;
            else if (pend_dly > fill) tap = 0;
            else                      tap = hist[n - pend_dly];
            wv = pend_data;
`ifdef DELAY_FEEDBACK_EN
            if (pend_dly != 0) wv = sat16(pend_data + (tap >>> FB_SH));
`endif
            hist.push_back(wv);
            e_valid = 1;
            e_dry   = pend_data;
            e_del   = tap;
            busy    = 0;
        end else begin
            e_valid = 0;
            if (stb) begin
                busy      = 1;
                pend_data = d;
                pend_dly  = dl;
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare mid-cycle
    task automatic step(input string tag, input bit stb, input int d,
                        input int dl, input bit rst);
        sampleStb = stb;
        inData    = DATA_W'(d);
        delay     = ADDR_W'(dl);
        resetN    = rst;
        @(posedge clkMain);
        model_edge(stb, int'(DATA_W'(d) & 16'hFFFF) - ((d & 32'h8000) != 0 ? 65536 : 0),
                   dl & (DEPTH - 1), rst);
        @(negedge clkMain);
        check({tag, ".valid"}, 32'(outValid), e_valid);
        check({tag, ".dry"}, 32'(outDry), e_dry);
        check({tag, ".delayed"}, 32'(outDelayed), e_del);
    endtask

    task automatic idle(input string tag, input int dl);
        step(tag, 1'b0, int'($urandom_range(0, 65535)) - 32768, dl, 1'b1);
    endtask

    initial begin
        sampleStb = 1'b0;
        inData    = '0;
        delay     = '0;
        resetN    = 1'b0;

        // Reset
        step("reset", 1'b0, 0, 0, 1'b0);
        step("reset", 1'b0, 0, 0, 1'b0);

        // Strobe every 4 cycles, delay 3
        for (int n = 1; n <= 8; n++) begin
            step("d3", 1'b1, n, 3, 1'b1);
            for (int k = 0; k < 3; k++) idle("d3", 3);
        end
        check("d3.last_tap", 32'(outDelayed), 5);

        // Bypass delay 0
        step("byp", 1'b1, 100, 0, 1'b1);
        idle("byp", 0);
        check("byp.first", 32'(outDelayed), 100);
        step("byp", 1'b1, -200, 0, 1'b1);
        idle("byp", 0);
        check("byp.second_tap", 32'(outDelayed), -200);
        check("byp.second_dry", 32'(outDry), -200);

        // Max delay right after reset, back-to-back, across pointer wrap
        step("rst2", 1'b0, 0, 0, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            step("dmax", 1'b1, n, DEPTH - 1, 1'b1);
            idle("dmax", DEPTH - 1);
        end
        check("dmax.last_tap", 32'(outDelayed), 25);

        // Strobe held two cycles: second one ignored
        step("dbl", 1'b1, 500, 1, 1'b1);
        step("dbl", 1'b1, 600, 1, 1'b1);
        idle("dbl", 1);
        step("dbl", 1'b1, 700, 1, 1'b1);
        idle("dbl", 1);
        check("dbl.prev", 32'(outDelayed), 500);

        // Reset while writing: output and write discarded
        step("rstw", 1'b1, 900, 1, 1'b1);
        step("rstw", 1'b0, 0, 1, 1'b0);
        check("rstw.no_valid", 32'(outValid), 0);
        for (int n = 1; n <= 6; n++) begin
            step("dchg", 1'b1, n, 3, 1'b1);
            idle("dchg", 3);
        end
        // Delay input changes between strobes: no effect yet
        for (int k = 0; k < 3; k++) idle("dchg", 5);
        check("dchg.hold", 32'(outDelayed), 3);
        step("dchg", 1'b1, 7, 5, 1'b1);
        idle("dchg", 5);
        check("dchg.new", 32'(outDelayed), 2);

        // Randomised traffic with occasional reset
        for (int c = 0; c < 4000; c++) begin
            bit stb;
            bit rst;
            stb = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 199) != 0);
            step("rand", stb, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, DEPTH - 1)), rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
